rv_mc_ctrl_bus: RTL and testbench

Multi-cycle RV32I control unit for the APB-attached core. It is the parametrised successor to the current FSM controller and adds these capabilities:
- instruction fetch over a ready/valid handshake into an internal instruction register (IR);
- a bounded bus-wait timeout;
- slave-error handling;
- illegal-opcode detection with a trap state.

It drives the existing datapath mux/enable signals and the data-bus master (transfer/busWe/strb).

---
 rtl/rv_mc_ctrl_bus_if.sv | 34 +++
 rtl/rv_mc_ctrl_bus.sv | 188 ++++++++++++++++++
 tb/tb_rv_mc_ctrl_bus.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mc_ctrl_bus_if.sv
// rtl/rv_mc_ctrl_bus_if.sv - fetch handshake, datapath control and data-bus master signals of rv_mc_ctrl_bus
interface rv_mc_ctrl_bus_if;
  logic        iReq;
  logic        iReady;
  logic [31:0] iData;
  logic        PCEn;
  logic        regFileWe;
  logic        aluSrcMuxSel;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [2:0]  strb;
  logic        busWe;
  logic        transfer;
  logic        ready;
  logic        busErr;
  logic        trap;
  logic [1:0]  trapCause;
  logic        trapPcSel;

  modport master (
    output iReq, PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
           branch, jal, jalr, strb, busWe, transfer, trap, trapCause, trapPcSel,
    input  iReady, iData, ready, busErr
  );

  modport slave (
    input  iReq, PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel,
           branch, jal, jalr, strb, busWe, transfer, trap, trapCause, trapPcSel,
    output iReady, iData, ready, busErr
  );
endinterface

// File: rtl/rv_mc_ctrl_bus.sv
// rtl/rv_mc_ctrl_bus.sv - multi-cycle RV32I control FSM with fetch handshake, bus timeout and traps
// Optional: define TRAP_RESUME_EN for a one-cycle trap that redirects the PC and resumes fetching.
module rv_mc_ctrl_bus #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  rv_mc_ctrl_bus_if.master  bus
);

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_R_EXE, ST_I_EXE, ST_B_EXE, ST_LU_EXE, ST_AU_EXE,
    ST_J_EXE, ST_JL_EXE, ST_S_EXE, ST_S_MEM, ST_L_EXE, ST_L_MEM, ST_L_WB, ST_TRAP
  } state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_ir;
  logic [TO_W-1:0]   r_wait_cnt;
  logic [1:0]        r_trap_cause, w_next_cause;
  logic              w_ir_load;
  logic              w_wait_inc;
  logic              w_timeout;
  logic [3:0]        w_op;
  logic              w_unused_ir;

  assign w_op        = {r_ir[30], r_ir[14:12]};
  assign w_timeout   = (r_wait_cnt == TO_W'(TIMEOUT - 1));
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_ir         <= '0;
      r_wait_cnt   <= '0;
      r_trap_cause <= 2'd0;
    end else begin
      r_state      <= w_next;
      r_trap_cause <= w_next_cause;
      if (w_ir_load)
        r_ir <= bus.iData;
      // Every state change restarts the wait window; counting saturates.
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_wait_inc && (r_wait_cnt != {TO_W{1'b1}}))
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next             = r_state;
    w_next_cause       = r_trap_cause;
    w_ir_load          = 1'b0;
    w_wait_inc         = 1'b0;
    bus.iReq           = 1'b0;
    bus.PCEn           = 1'b0;
    bus.regFileWe      = 1'b0;
    bus.aluSrcMuxSel   = 1'b0;
    bus.aluControl     = 4'b0000;
    bus.RFWDSrcMuxSel  = 3'd0;
    bus.branch         = 1'b0;
    bus.jal            = 1'b0;
    bus.jalr           = 1'b0;
    bus.strb           = r_ir[14:12];
    bus.busWe          = 1'b0;
    bus.transfer       = 1'b0;
    bus.trap           = 1'b0;
    bus.trapCause      = r_trap_cause;
    bus.trapPcSel      = 1'b0;

    case (r_state)
      ST_FETCH: begin
        bus.iReq = 1'b1;
        if (bus.iReady) begin
          w_ir_load = 1'b1;
          w_next    = ST_DECODE;
        end else if (w_timeout) begin
          w_next       = ST_TRAP;
          w_next_cause = 2'd2;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        case (r_ir[6:0])
          7'b0110011: w_next = ST_R_EXE;
          7'b0010011: w_next = ST_I_EXE;
          7'b1100011: w_next = ST_B_EXE;
          7'b0110111: w_next = ST_LU_EXE;
          7'b0010111: w_next = ST_AU_EXE;
          7'b1101111: w_next = ST_J_EXE;
          7'b1100111: w_next = ST_JL_EXE;
          7'b0100011: w_next = ST_S_EXE;
          7'b0000011: w_next = ST_L_EXE;
          default: begin
            w_next       = ST_TRAP;
            w_next_cause = 2'd1;
          end
        endcase
      end
      ST_R_EXE: begin
        bus.regFileWe  = 1'b1;
        bus.aluControl = w_op;
        bus.PCEn       = 1'b1;
        w_next         = ST_FETCH;
      end
      ST_I_EXE: begin
        // Only SRAI carries a meaningful IR[30]; for other immediates it is immediate data.
        bus.regFileWe    = 1'b1;
        bus.aluSrcMuxSel = 1'b1;
        bus.aluControl   = (w_op == 4'b1101) ? w_op : {1'b0, w_op[2:0]};
        bus.PCEn         = 1'b1;
        w_next           = ST_FETCH;
      end
      ST_B_EXE: begin
        bus.branch     = 1'b1;
        bus.aluControl = w_op;
        bus.PCEn       = 1'b1;
        w_next         = ST_FETCH;
      end
      ST_LU_EXE, ST_AU_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = (r_state == ST_LU_EXE) ? 3'd2 : 3'd3;
        bus.PCEn          = 1'b1;
        w_next            = ST_FETCH;
      end
      ST_J_EXE, ST_JL_EXE: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd4;
        bus.jal           = 1'b1;
        bus.jalr          = (r_state == ST_JL_EXE);
        bus.PCEn          = 1'b1;
        w_next            = ST_FETCH;
      end
      ST_S_EXE: begin
        bus.aluSrcMuxSel = 1'b1;
        w_next           = ST_S_MEM;
      end
      ST_L_EXE: begin
        bus.aluSrcMuxSel  = 1'b1;
        bus.RFWDSrcMuxSel = 3'd1;
        w_next            = ST_L_MEM;
      end
      ST_S_MEM, ST_L_MEM: begin
        bus.transfer      = 1'b1;
        bus.aluSrcMuxSel  = 1'b1;
        bus.busWe         = (r_state == ST_S_MEM);
        bus.RFWDSrcMuxSel = (r_state == ST_L_MEM) ? 3'd1 : 3'd0;
        // A ready response on the last allowed cycle still completes the access.
        if (bus.ready) begin
          if (bus.busErr) begin
            w_next       = ST_TRAP;
            w_next_cause = 2'd3;
          end else if (r_state == ST_S_MEM) begin
            bus.PCEn = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_L_WB;
          end
        end else if (w_timeout) begin
          w_next       = ST_TRAP;
          w_next_cause = 2'd2;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_L_WB: begin
        bus.regFileWe     = 1'b1;
        bus.RFWDSrcMuxSel = 3'd1;
        bus.PCEn          = 1'b1;
        w_next            = ST_FETCH;
      end
      ST_TRAP: begin
        bus.trap = 1'b1;
        bus.strb = 3'd0;
`ifdef TRAP_RESUME_EN
        bus.PCEn      = 1'b1;
        bus.trapPcSel = 1'b1;
        w_next        = ST_FETCH;
`else
        w_next = ST_TRAP;
`endif
      end
      default: w_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_rv_mc_ctrl_bus.sv
// tb/tb_rv_mc_ctrl_bus.sv - directed self-checking bench for rv_mc_ctrl_bus (TIMEOUT=16)
module tb_rv_mc_ctrl_bus;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_mc_ctrl_bus_if bus_if ();

  rv_mc_ctrl_bus #(.TIMEOUT(16), .TO_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    bus_if.iReady = 1'b1;
    bus_if.iData  = instr;
    tick();
    bus_if.iReady = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // {regFileWe, aluSrcMuxSel, aluControl[3:0], RFWDSrcMuxSel[2:0], branch, jal, jalr, PCEn}
  function automatic logic [12:0] ctrl();
    return {bus_if.regFileWe, bus_if.aluSrcMuxSel, bus_if.aluControl, bus_if.RFWDSrcMuxSel,
            bus_if.branch, bus_if.jal, bus_if.jalr, bus_if.PCEn};
  endfunction

  logic [31:0] tv_instr [10];
  logic [12:0] tv_ctrl  [10];
  string       tv_name  [10];
  int          n;
  logic        pc_seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_instr[0] = 32'h00B50533; tv_ctrl[0] = {1'b1, 1'b0, 4'b0000, 3'd0, 4'b0001}; tv_name[0] = "add";
    tv_instr[1] = 32'h40B50533; tv_ctrl[1] = {1'b1, 1'b0, 4'b1000, 3'd0, 4'b0001}; tv_name[1] = "sub";
    tv_instr[2] = 32'h4030D093; tv_ctrl[2] = {1'b1, 1'b1, 4'b1101, 3'd0, 4'b0001}; tv_name[2] = "srai";
    tv_instr[3] = 32'h00309093; tv_ctrl[3] = {1'b1, 1'b1, 4'b0001, 3'd0, 4'b0001}; tv_name[3] = "slli";
    tv_instr[4] = 32'h40000093; tv_ctrl[4] = {1'b1, 1'b1, 4'b0000, 3'd0, 4'b0001}; tv_name[4] = "addi_b30";
    tv_instr[5] = 32'h00B51463; tv_ctrl[5] = {1'b0, 1'b0, 4'b0001, 3'd0, 4'b1001}; tv_name[5] = "bne";
    tv_instr[6] = 32'h000000B7; tv_ctrl[6] = {1'b1, 1'b0, 4'b0000, 3'd2, 4'b0001}; tv_name[6] = "lui";
    tv_instr[7] = 32'h00000097; tv_ctrl[7] = {1'b1, 1'b0, 4'b0000, 3'd3, 4'b0001}; tv_name[7] = "auipc";
    tv_instr[8] = 32'h0000006F; tv_ctrl[8] = {1'b1, 1'b0, 4'b0000, 3'd4, 4'b0101}; tv_name[8] = "jal";
    tv_instr[9] = 32'h00008067; tv_ctrl[9] = {1'b1, 1'b0, 4'b0000, 3'd4, 4'b0111}; tv_name[9] = "jalr";

    reset = 1'b0;
    bus_if.iReady = 1'b0;
    bus_if.iData  = 32'h0;
    bus_if.ready  = 1'b0;
    bus_if.busErr = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_ireq", bus_if.iReq, 1);
    chk("rst_ctrl", ctrl(), 0);
    chk("rst_transfer", {bus_if.transfer, bus_if.busWe, bus_if.strb}, 0);
    chk("rst_trap", {bus_if.trap, bus_if.trapCause, bus_if.trapPcSel}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      fetch(tv_instr[i]);
      if (i == 0) begin
        chk("decode_ireq", bus_if.iReq, 0);
        chk("decode_ctrl", ctrl(), 0);
      end
      tick();
      chk({"exe_", tv_name[i]}, ctrl(), tv_ctrl[i]);
      tick();
      chk({"back_fetch_", tv_name[i]}, bus_if.iReq, 1);
    end

    // LW with ready after three wait cycles
    fetch(32'h0002A303);
    tick();
    chk("lw_exe_ctrl", ctrl(), {1'b0, 1'b1, 4'b0000, 3'd1, 4'b0000});
    chk("lw_exe_transfer", bus_if.transfer, 0);
    tick();
    chk("lw_strb", bus_if.strb, 3'b010);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_if.transfer) n++;
      bus_if.ready = (i == 3);
      tick();
    end
    bus_if.ready = 1'b0;
    chk("lw_transfer_cycles", n, 4);
    chk("lw_wb_ctrl", ctrl(), {1'b1, 1'b0, 4'b0000, 3'd1, 4'b0001});
    tick();
    chk("lw_back_fetch", bus_if.iReq, 1);

    // SW with ready never asserted
    fetch(32'h0062A023);
    tick();
    chk("sw_exe_ctrl", ctrl(), {1'b0, 1'b1, 4'b0000, 3'd0, 4'b0000});
    chk("sw_exe_buswe", bus_if.busWe, 0);
    tick();
    n = 0;
    pc_seen = 1'b0;
    while (bus_if.transfer && n < 40) begin
      n++;
      pc_seen = pc_seen | bus_if.PCEn;
      tick();
    end
    chk("sw_wait_cycles", n, 16);
    chk("sw_wait_pcen", pc_seen, 0);
    chk("sw_to_trap", {bus_if.trap, bus_if.trapCause}, {1'b1, 2'd2});
    chk("sw_trap_buswe", bus_if.busWe, 0);
`ifdef TRAP_RESUME_EN
    chk("sw_trap_resume", {bus_if.trapPcSel, bus_if.PCEn}, 2'b11);
    tick();
    chk("sw_resume_fetch", {bus_if.iReq, bus_if.trap, bus_if.trapCause}, {1'b1, 1'b0, 2'd2});
`else
    chk("sw_trap_nopc", {bus_if.trapPcSel, bus_if.PCEn}, 2'b00);
    tick();
    chk("sw_trap_sticky", {bus_if.trap, bus_if.trapCause}, {1'b1, 2'd2});
`endif
    do_reset();
    chk("cause_after_reset", bus_if.trapCause, 0);

    // SW with ready exactly on the timeout cycle completes
    fetch(32'h0062A023);
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("sw_edge_still_mem", bus_if.transfer, 1);
    bus_if.ready = 1'b1;
    #1;
    chk("sw_edge_pcen", bus_if.PCEn, 1);
    tick();
    bus_if.ready = 1'b0;
    chk("sw_edge_no_trap", {bus_if.trap, bus_if.iReq}, 2'b01);

    // SB with slave error
    fetch(32'h00628023);
    tick();
    tick();
    bus_if.ready  = 1'b1;
    bus_if.busErr = 1'b1;
    #1;
    chk("sb_err_pcen", bus_if.PCEn, 0);
    chk("sb_mem_buswe_strb", {bus_if.busWe, bus_if.strb}, {1'b1, 3'b000});
    tick();
    bus_if.ready  = 1'b0;
    bus_if.busErr = 1'b0;
    chk("sb_trap_cause", {bus_if.trap, bus_if.trapCause}, {1'b1, 2'd3});
    chk("sb_trap_bus", {bus_if.busWe, bus_if.transfer, bus_if.regFileWe}, 0);
`ifdef TRAP_RESUME_EN
    chk("sb_trap_resume", {bus_if.trapPcSel, bus_if.PCEn}, 2'b11);
    tick();
    chk("sb_resume_fetch", {bus_if.iReq, bus_if.trapCause}, {1'b1, 2'd3});
`else
    chk("sb_trap_nopc", {bus_if.trapPcSel, bus_if.PCEn}, 2'b00);
    tick();
    chk("sb_trap_sticky", bus_if.trap, 1);
`endif
    do_reset();

    // Illegal opcode
    fetch(32'h0000007F);
    chk("illegal_decode", {bus_if.trap, bus_if.iReq}, 0);
    tick();
    chk("illegal_trap", {bus_if.trap, bus_if.trapCause}, {1'b1, 2'd1});
    chk("illegal_no_write", {bus_if.regFileWe, bus_if.iReq}, 0);
    do_reset();

    // Fetch timeout
    n = 0;
    while (bus_if.iReq && n < 40) begin
      n++;
      tick();
    end
    chk("fetch_wait_cycles", n, 16);
    chk("fetch_timeout_cause", {bus_if.trap, bus_if.trapCause}, {1'b1, 2'd2});
    do_reset();

    // Async reset in the middle of a load access
    fetch(32'h0002A303);
    tick();
    tick();
    chk("lmem_transfer", bus_if.transfer, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_bus", {bus_if.iReq, bus_if.transfer}, 2'b10);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
